// File: rtl/mem_burst_ram.sv
// mem_burst_ram: memory-side responder for the 4-word burst mem_req/mem_gnt
// interface. One request is accepted at a time; the grant pulse follows
// GNT_DELAY idle cycles. Exactly four words are then written into, or read
// from, an internal synchronous single-port RAM.
//
// Handshake: mem_req is a level held until mem_gnt. mem_write and mem_addr are
// stable while mem_req is high. mem_gnt is a one-cycle registered pulse. Write
// words are sampled on the grant cycle and the three cycles after it. Read words
// appear on mem_rd_data one cycle after their RAM read, at grant+1 .. grant+4.
//
// Optional feature: define MEM_BURST_RAM_CHECK_EN to compile in a sticky
// protocol checker that drives proto_err. Without it, proto_err is tied low.
module mem_burst_ram #(
  parameter int LOG2BYTEWIDTH = 3,
  parameter int ADDRWIDTH     = 20,
  parameter int LOG2MEMSIZE   = 12,
  parameter int GNT_DELAY     = 2,
  localparam int DATAWIDTH    = 8 << LOG2BYTEWIDTH
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 mem_req,
  input  logic                 mem_write,
  input  logic [ADDRWIDTH-1:0] mem_addr,
  input  logic [DATAWIDTH-1:0] mem_wr_data,
  output logic                 mem_gnt,
  output logic [DATAWIDTH-1:0] mem_rd_data,
  output logic                 busy,
  output logic                 proto_err
);

  localparam int IDX_W  = LOG2MEMSIZE - LOG2BYTEWIDTH;
  localparam int LINE_W = IDX_W - 2;
  localparam int DEPTH  = 1 << IDX_W;
  // The WAIT counter counts down to zero, so it is loaded with one less than the delay.
  localparam logic [3:0] DLY_INIT = (GNT_DELAY == 0) ? 4'd0 : 4'(GNT_DELAY - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GRANT,
    ST_WR_BURST,
    ST_RD_BURST
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           beat_q, beat_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic                 write_q, write_d;
  logic                 mem_gnt_q, mem_gnt_d;
  logic                 busy_q, busy_d;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;

  logic                 ram_we;
  logic                 ram_re;
  logic [IDX_W-1:0]     ram_addr;
  logic [DATAWIDTH-1:0] mem_array [DEPTH];

  // Next-state logic, RAM port control and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    line_d   = line_q;
    write_d  = write_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = {line_q, beat_q};
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          // The line base drops the two word-offset bits, so every burst is line-aligned.
          line_d  = mem_addr[LOG2MEMSIZE-1 -: LINE_W];
          write_d = mem_write;
          cnt_d   = DLY_INIT;
          state_d = (GNT_DELAY == 0) ? ST_GRANT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_GRANT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_GRANT: begin
        ram_addr = {line_q, 2'b00};
        ram_we   = write_q;
        ram_re   = !write_q;
        beat_d   = 2'd1;
        state_d  = write_q ? ST_WR_BURST : ST_RD_BURST;
      end
      ST_WR_BURST: begin
        ram_we = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = ST_IDLE;
      end
      ST_RD_BURST: begin
        ram_re = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    mem_gnt_d = (state_d == ST_GRANT);
    busy_d    = (state_d != ST_IDLE);
    // The read register holds its last value whenever no read is in progress.
    rd_data_d = ram_re ? mem_array[ram_addr] : rd_data_q;
  end

  // Control state and registered outputs; a reset aborts any burst in flight.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      beat_q    <= 2'd0;
      line_q    <= '0;
      write_q   <= 1'b0;
      mem_gnt_q <= 1'b0;
      busy_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      line_q    <= line_d;
      write_q   <= write_d;
      mem_gnt_q <= mem_gnt_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM array write port. The contents are deliberately neither reset nor initialised.
  always_ff @(posedge clk) begin
    if (ram_we) mem_array[ram_addr] <= mem_wr_data;
  end

  assign mem_gnt     = mem_gnt_q;
  assign busy        = busy_q;
  assign mem_rd_data = rd_data_q;

`ifdef MEM_BURST_RAM_CHECK_EN
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 err_q, err_d;
  logic                 viol;

  // Flag requester misbehaviour; this never feeds back into the state machine.
  always_comb begin
    addr_d = addr_q;
    viol   = 1'b0;
    if (state_q == ST_IDLE && mem_req) begin
      addr_d = mem_addr;
      if (mem_addr[LOG2BYTEWIDTH-1:0] != '0) viol = 1'b1;
    end
    if (state_q == ST_WAIT &&
        (!mem_req || mem_addr != addr_q || mem_write != write_q)) viol = 1'b1;
    // beat_q is still 1 in the cycle after the grant, when mem_req must already be low.
    if ((state_q == ST_WR_BURST || state_q == ST_RD_BURST) && beat_q == 2'd1 && mem_req)
      viol = 1'b1;
    err_d = err_q | viol;
  end

  // Sticky error flag; only reset_l clears it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  logic unused_addr;
  assign unused_addr = ^mem_addr;
  assign proto_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_ram.sv
// Bench for mem_burst_ram: directed bursts (alignment, aliasing, back-to-back,
// reset mid-burst, protocol checker), followed by random bursts. Expected read
// data comes from a word-addressed reference memory.
module tb_mem_burst_ram;

  localparam int L2B     = 3;
  localparam int AW      = 20;
  localparam int L2M     = 12;
  localparam int GNT_DLY = 2;
  localparam int DW      = 8 << L2B;
  localparam int BYTES   = 1 << L2B;

`ifdef MEM_BURST_RAM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk;
  logic          reset_l;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_gnt;
  logic [DW-1:0] mem_rd_data;
  logic          busy;
  logic          proto_err;

  mem_burst_ram #(
    .LOG2BYTEWIDTH(L2B),
    .ADDRWIDTH    (AW),
    .LOG2MEMSIZE  (L2M),
    .GNT_DELAY    (GNT_DLY)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_gnt    (mem_gnt),
    .mem_rd_data(mem_rd_data),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [int];
  int            written_lines[$];
  logic [DW-1:0] wbuf [4];
  bit            err_exp = 1'b0;
  int            last_g  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address map: aliasing above the memory size, line-aligned base.
  function automatic int word_base(input logic [AW-1:0] a);
    int idx;
    idx = (int'(a) % (1 << L2M)) / BYTES;
    return idx - (idx % 4);
  endfunction

  // One burst. The call starts in cycle R and returns in cycle G+4.
  // drop: lower mem_req during WAIT; hold: keep mem_req high at G+1;
  // abort_k: return at the start of cycle G+abort_k without finishing.
  task automatic burst(input bit wr, input logic [AW-1:0] addr,
                       input bit drop, input bit hold, input int abort_k);
    int            r;
    int            g;
    int            base;
    bit            got;
    logic [DW-1:0] e;
    r    = cyc;
    base = word_base(addr);
    for (int k = 0; k < 4; k++) begin
      if (wr) model_mem[base + k] = wbuf[k];
      else    exp_q.push_back(model_mem.exists(base + k) ? model_mem[base + k] : '0);
    end
    if (wr) written_lines.push_back(base / 4);
    mem_req     = 1'b1;
    mem_write   = wr;
    mem_addr    = addr;
    mem_wr_data = wr ? wbuf[0] : {$urandom, $urandom};
    got = 1'b0;
    g   = 0;
    for (int t = 1; t <= 40 && !got; t++) begin
      tick();
      if (t == 1) begin
        check_eq("busy_start", busy, 1);
        if (drop) begin
          mem_req = 1'b0;
          err_exp = err_exp | CHK;
        end
      end
      if (t == 2 && drop) check_eq("err_drop", proto_err, err_exp);
      if (mem_gnt) begin
        got = 1'b1;
        g   = cyc;
      end
    end
    if (!got) begin
      check_eq("gnt_timeout", 0, 1);
      mem_req = 1'b0;
      exp_q.delete();
      return;
    end
    check_eq("gnt_time", g, r + 1 + GNT_DLY);
    last_g = g;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == abort_k) return;
      if (k == 1) begin
        check_eq("gnt_pulse", mem_gnt, 0);
        mem_req = hold;
        if (hold) err_exp = err_exp | CHK;
      end
      if (k == 2) begin
        mem_req = 1'b0;
        if (hold) check_eq("err_hold", proto_err, err_exp);
      end
      if (wr && k <= 3) mem_wr_data = wbuf[k];
      if (!wr) begin
        e = exp_q.pop_front();
        check_eq("rd_data", mem_rd_data, e);
      end
      if (k == 3) check_eq("busy_end", busy, 1);
      if (k == 4) check_eq("busy_idle", busy, 0);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_gnt", mem_gnt, 0);
    check_eq("rst_rd_data", mem_rd_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_proto_err", proto_err, 0);
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    err_exp = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check_reset_outputs();
    reset_l = 1'b1;
    tick();
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int            g1;
    logic [AW-1:0] a;
    int            l;
    reset_l     = 1'b0;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    tick();
    do_reset();

    // alignment: write line 0x120, read from 0x128 inside the same line
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    burst(1'b1, 20'h00120, 1'b0, 1'b0, 0);
    repeat (3) tick();
    burst(1'b0, 20'h00128, 1'b0, 1'b0, 0);
    check_eq("proto_err_clean", proto_err, err_exp);

    // aliasing: address bits above the memory size are ignored
    wbuf[0] = 64'hA0; wbuf[1] = 64'hA1; wbuf[2] = 64'hA2; wbuf[3] = 64'hA3;
    burst(1'b1, 20'h01040, 1'b0, 1'b0, 0);
    tick();
    burst(1'b0, 20'h00040, 1'b0, 1'b0, 0);

    // back-to-back: read request already present at G+4 of a write
    for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
    burst(1'b1, 20'h00200, 1'b0, 1'b0, 0);
    g1 = last_g;
    burst(1'b0, 20'h00200, 1'b0, 1'b0, 0);
    check_eq("b2b_spacing", last_g - g1, 5 + GNT_DLY);

    // random bursts
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
        a = AW'($urandom) & ~AW'(BYTES - 1);
        burst(1'b1, a, 1'b0, 1'b0, 0);
      end else begin
        l = written_lines[$urandom_range(0, written_lines.size() - 1)];
        a = AW'(($urandom_range(0, 255) << L2M) | (l * 4 * BYTES) | ($urandom_range(0, 3) * BYTES));
        burst(1'b0, a, 1'b0, 1'b0, 0);
      end
      check_eq("proto_err_rand", proto_err, err_exp);
      repeat ($urandom_range(0, 3)) tick();
    end

    // reset mid read burst at G+2
    burst(1'b0, 20'h00040, 1'b0, 1'b0, 2);
    reset_l = 1'b0;
    err_exp = 1'b0;
    exp_q.delete();
    tick();
    check_reset_outputs();
    tick();
    reset_l = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check_eq("no_gnt_after_rst", mem_gnt, 0);
    end
    burst(1'b0, 20'h00040, 1'b0, 1'b0, 0);

    // protocol checker: drop mem_req during WAIT, then a clean burst
    wbuf[0] = 64'h55; wbuf[1] = 64'h66; wbuf[2] = 64'h77; wbuf[3] = 64'h88;
    burst(1'b1, 20'h00300, 1'b1, 1'b0, 0);
    check_eq("err_sticky_1", proto_err, err_exp);
    tick();
    burst(1'b0, 20'h00300, 1'b0, 1'b0, 0);
    check_eq("err_sticky_2", proto_err, err_exp);
    do_reset();
    // hold mem_req at G+1
    burst(1'b0, 20'h00300, 1'b0, 1'b1, 0);
    check_eq("err_after_hold", proto_err, err_exp);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
